pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 104 ++++++++++
 tb/tb_pipelined_adder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Chunked ripple-carry adder/subtractor: STAGES registered chunks of WIDTH/STAGES bits, latency STAGES cycles.
// Valid/ready handshake; the whole pipeline freezes while the output holds a result that is not taken.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int CW = WIDTH / STAGES;

  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             ovf_q;

  logic             v_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic [CW:0]      part  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             ovf_d;
  logic             adv;

  assign adv = ~vld_q[STAGES-1] | OUT_READY;

  // Subtraction is A + ~B + ~CIN, so stage 0 sees the inverted operand and carry.
  always_comb begin
    a_in[0] = A;
    b_in[0] = SUB ? ~B : B;
    c_in[0] = CIN ^ SUB;
    s_in[0] = '0;
    v_in[0] = IN_VALID;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = cy_q[k-1];
      s_in[k] = s_q[k-1];
      v_in[k] = vld_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_in[k][k*CW +: CW]}
              + {1'b0, b_in[k][k*CW +: CW]}
              + {{CW{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*CW +: CW] = part[k][CW-1:0];
    end
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
            (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  // Data registers load only behind a valid bit, so bubbles leave the last result on SUM.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k]  <= a_in[k];
          b_q[k]  <= b_in[k];
          cy_q[k] <= part[k][CW];
          s_q[k]  <= s_d[k];
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign IN_READY  = adv;
  assign SUM       = s_q[STAGES-1];
  assign COUT      = cy_q[STAGES-1];
  assign OVF       = ovf_q;
  assign OUT_VALID = vld_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 16-bit/4-stage instance plus the 4-bit/1-stage legacy configuration.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [15:0] a_i, b_i, sum_o;
  logic        cin_i, sub_i, in_valid, in_ready, out_ready, out_valid, cout_o, ovf_o;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, sub4, inv4, inr4, outv4, outr4, cout4, ovf4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  pipelined_adder dut (
    .CLK(clk), .RSTN(rstn), .A(a_i), .B(b_i), .CIN(cin_i), .SUB(sub_i),
    .IN_VALID(in_valid), .IN_READY(in_ready), .SUM(sum_o), .COUT(cout_o),
    .OVF(ovf_o), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1)) dut4 (
    .CLK(clk), .RSTN(rstn), .A(a4), .B(b4), .CIN(cin4), .SUB(sub4),
    .IN_VALID(inv4), .IN_READY(inr4), .SUM(sum4), .COUT(cout4),
    .OVF(ovf4), .OUT_VALID(outv4), .OUT_READY(outr4)
  );

  // Integer-arithmetic reference: unsigned result for SUM/COUT, signed range test for OVF.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t   r;
    longint m, ua, ub, uc, full, sa, sb, sr;
    m  = longint'(1) << w;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    uc = cin ? 1 : 0;
    if (!sub) begin
      full   = ua + ub + uc;
      r.cout = (full >= m);
    end else begin
      full   = ua - ub - uc;
      r.cout = (ua >= ub + uc);
    end
    r.sum = 16'((full + m) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sub ? sa - sb - uc : sa + sb + uc;
    r.ovf = (sr < -(m / 2)) || (sr >= m / 2);
    r.cyc = 0;
    return r;
  endfunction

  task automatic rand_op();
    a_i   = 16'($urandom);
    b_i   = 16'($urandom);
    cin_i = 1'($urandom);
    sub_i = 1'($urandom);
  endtask

  task automatic test_reset();
    int seen;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inv4 = 1'b0; outr4 = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    rand_op();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, sum_o, cout_o, ovf_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_init: got valid=%b sum=%h cout=%b ovf=%b, required all zero", out_valid, sum_o, cout_o, ovf_o);
    end
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rstn = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; rand_op();
    @(posedge clk); #1 in_valid = 1'b0; rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, sum_o, cout_o, ovf_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b sum=%h cout=%b ovf=%b, required all zero", out_valid, sum_o, cout_o, ovf_o);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_checks++;
    if ({outv4, sum4, cout4, ovf4} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_legacy: got valid=%b sum=%h cout=%b, required all zero", outv4, sum4, cout4);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_flush: got %0d ghost results, required 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [3:0]  tcs [4];
    logic [17:0] texp [4];
    int acc, oc;
    bit got;
    ta   = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0010};
    tb   = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    tcs  = '{4'b0000, 4'b0000, 4'b0001, 4'b0011};   // {..,cin,sub}
    texp = '{{16'h0000, 2'b10}, {16'h8000, 2'b01}, {16'hFFFE, 2'b00}, {16'h000E, 2'b10}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_i = ta[i]; b_i = tb[i]; cin_i = tcs[i][1]; sub_i = tcs[i][0]; in_valid = 1'b1;
      @(negedge clk);
      acc = cyc;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_in_ready: got %b required 1", i, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0; rand_op();
      got = 1'b0; oc = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (out_valid) begin got = 1'b1; oc = cyc; break; end
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL dir%0d_timeout: got no OUT_VALID in 10 cycles, required one", i);
      end else begin
        n_checks++;
        if (oc - acc != 4) begin
          n_fail++;
          $display("FAIL dir%0d_latency: got %0d required 4", i, oc - acc);
        end
        n_checks++;
        if ({sum_o, cout_o, ovf_o} !== texp[i]) begin
          n_fail++;
          $display("FAIL dir%0d_value: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   i, sum_o, cout_o, ovf_o, texp[i][17:2], texp[i][1], texp[i][0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, recv = 0;
    exp_t e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int t = 0; t < 40 && recv < 8; t++) begin
      in_valid = (sent < 8); rand_op();
      @(negedge clk);
      if (in_valid && in_ready) begin
        e = model(16, a_i, b_i, cin_i, sub_i); e.cyc = cyc; exp_q.push_back(e); sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got unexpected result %h, required none", sum_o);
        end else begin
          e = exp_q.pop_front(); recv++;
          if ({sum_o, cout_o, ovf_o} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL b2b_value: got %h/%b/%b required %h/%b/%b", sum_o, cout_o, ovf_o, e.sum, e.cout, e.ovf);
          end
          n_checks++;
          if (cyc - e.cyc != 4) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d required 4", cyc - e.cyc);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (recv != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results required 8", recv);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, recv = 0;
    exp_t e;
    logic [18:0] snap = '0;
    exp_q.delete();
    for (int t = 0; t < 80 && recv < 12; t++) begin
      out_ready = !(t >= 5 && t < 10);
      in_valid = (sent < 12); rand_op();
      @(negedge clk);
      if (t >= 5 && t < 10) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready: got %b required 0 at stall cycle %0d", in_ready, t);
        end
        n_checks++;
        if (t == 5) begin
          snap = {out_valid, cout_o, ovf_o, sum_o};
          if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_out_valid: got %b required 1", out_valid);
          end
        end else if ({out_valid, cout_o, ovf_o, sum_o} !== snap) begin
          n_fail++;
          $display("FAIL bp_stable: got %h required %h at stall cycle %0d", {out_valid, cout_o, ovf_o, sum_o}, snap, t);
        end
      end
      if (in_valid && in_ready) begin
        e = model(16, a_i, b_i, cin_i, sub_i); exp_q.push_back(e); sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got unexpected result %h, required none", sum_o);
        end else begin
          e = exp_q.pop_front(); recv++;
          if ({sum_o, cout_o, ovf_o} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL bp_value: got %h/%b/%b required %h/%b/%b", sum_o, cout_o, ovf_o, e.sum, e.cout, e.ovf);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (recv != 12 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results (%0d pending) required 12 (0 pending)", recv, exp_q.size());
    end
  endtask

  task automatic test_random();
    int sent = 0, recv = 0;
    exp_t e;
    exp_q.delete();
    for (int t = 0; t < 400; t++) begin
      if (t >= 300 && exp_q.size() == 0 && !out_valid) break;
      in_valid  = (t < 300) && ($urandom_range(0, 9) < 7);
      out_ready = (t >= 300) || ($urandom_range(0, 9) < 6);
      rand_op();
      @(negedge clk);
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL rnd_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (in_valid && in_ready) begin
        e = model(16, a_i, b_i, cin_i, sub_i); exp_q.push_back(e); sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra: got unexpected result %h, required none", sum_o);
        end else begin
          e = exp_q.pop_front(); recv++;
          if ({sum_o, cout_o, ovf_o} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL rnd_value: got %h/%b/%b required %h/%b/%b", sum_o, cout_o, ovf_o, e.sum, e.cout, e.ovf);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (recv != sent || sent == 0) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d results required %0d", recv, sent);
    end
  endtask

  task automatic test_legacy();
    logic [3:0] la [2];
    logic [3:0] lb [2];
    logic [5:0] lexp [2];
    exp_t e;
    int sent = 0, recv = 0;
    la = '{4'b1111, 4'b1001};
    lb = '{4'b1101, 4'b1111};
    lexp = '{{4'b1101, 2'b10}, {4'b1001, 2'b10}};
    outr4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a4 = la[i]; b4 = lb[i]; cin4 = 1'b1; sub4 = 1'b0; inv4 = 1'b1;
      @(posedge clk); #1 inv4 = 1'b0; a4 = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if ({outv4, sum4, cout4, ovf4} !== {1'b1, lexp[i]}) begin
        n_fail++;
        $display("FAIL legacy%0d: got valid=%b sum=%b cout=%b ovf=%b, required valid=1 sum=%b cout=%b ovf=%b",
                 i, outv4, sum4, cout4, ovf4, lexp[i][5:2], lexp[i][1], lexp[i][0]);
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    for (int t = 0; t < 30 && recv < 20; t++) begin
      inv4 = (sent < 20);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
      @(negedge clk);
      if (outv4 && outr4) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL legacy_extra: got unexpected result %b, required none", sum4);
        end else begin
          e = exp_q.pop_front(); recv++;
          if ({12'd0, sum4, cout4, ovf4} !== {e.sum, e.cout, e.ovf} || cyc - e.cyc != 1) begin
            n_fail++;
            $display("FAIL legacy_rnd: got %b/%b/%b lat %0d required %b/%b/%b lat 1",
                     sum4, cout4, ovf4, cyc - e.cyc, e.sum[3:0], e.cout, e.ovf);
          end
        end
      end
      if (inv4 && inr4) begin
        e = model(4, {12'd0, a4}, {12'd0, b4}, cin4, sub4); e.cyc = cyc; exp_q.push_back(e); sent++;
      end
      @(posedge clk); #1;
    end
    inv4 = 1'b0;
    n_checks++;
    if (recv != 20) begin
      n_fail++;
      $display("FAIL legacy_count: got %0d results required 20", recv);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_legacy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
